// File: rtl/alu_pkg.sv
// Opcode map and shared types for the sequential ALU, also imported by the instruction decoder.
package alu_pkg;

    typedef logic [4:0] op_t;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_t;

    localparam op_t ALU_OP_ADD = 5'b00000;
    localparam op_t ALU_OP_SUB = 5'b00001;
    localparam op_t ALU_OP_ADC = 5'b00010;
    localparam op_t ALU_OP_SBC = 5'b00011;
    localparam op_t ALU_OP_AND = 5'b00100;
    localparam op_t ALU_OP_OR  = 5'b00101;
    localparam op_t ALU_OP_NOT = 5'b00110;
    localparam op_t ALU_OP_XOR = 5'b00111;
    localparam op_t ALU_OP_INC = 5'b01000;
    localparam op_t ALU_OP_DEC = 5'b01001;
    localparam op_t ALU_OP_CMP = 5'b01010;
    localparam op_t ALU_OP_TST = 5'b01011;
    localparam op_t ALU_OP_SHL = 5'b10000;
    localparam op_t ALU_OP_SHR = 5'b10001;
    localparam op_t ALU_OP_SAL = 5'b10010;
    localparam op_t ALU_OP_SAR = 5'b10011;
    localparam op_t ALU_OP_ROL = 5'b10100;
    localparam op_t ALU_OP_ROR = 5'b10101;
    localparam op_t ALU_OP_RCL = 5'b10110;
    localparam op_t ALU_OP_RCR = 5'b10111;
    localparam op_t ALU_OP_MUL = 5'b11000;
    localparam op_t ALU_OP_DIV = 5'b11001;

    function automatic logic is_multicycle(input op_t op);
        return (op == ALU_OP_MUL) || (op == ALU_OP_DIV);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result bus between the register file side (master) and the ALU (slave).
interface alu_seq_if import alu_pkg::*; #(parameter int WIDTH = 8);

    logic             start;
    op_t              operation;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             CF;
    logic             ZF;
    logic             SF;
    logic             OF;
    logic             busy;
    logic             done;

    modport master (
        output start, operation, A, B,
        input  result, result_hi, CF, ZF, SF, OF, busy, done
    );

    modport slave (
        input  start, operation, A, B,
        output result, result_hi, CF, ZF, SF, OF, busy, done
    );

endinterface

// File: rtl/alu_muldiv_seq.sv
// Iterative unsigned multiply (shift-add) and restoring divide sharing one 2*WIDTH accumulator.
// The final iteration's value is presented combinationally so the parent can register it on the done edge.
module alu_muldiv_seq import alu_pkg::*; #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             mode_div,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    md_state_t          state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc, acc_step;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH:0]     mul_sum, div_sh, div_diff;
    logic               last;

    assign busy = (state == MD_RUN);
    assign last = busy && (cnt == CNT_W'(WIDTH - 1));
    assign done = last;

    always_ff @(posedge clk) begin
        if (reset) state <= MD_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MD_IDLE: if (start) state_nxt = MD_RUN;
            MD_RUN:  if (last)  state_nxt = MD_IDLE;
            default: state_nxt = MD_IDLE;
        endcase
    end

    // Multiply keeps the multiplier in the low half and adds into the high half before shifting right;
    // divide shifts the dividend left into the remainder half and restores when the trial subtract goes negative.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff = div_sh - {1'b0, opnd};
        if (mode_div) begin
            if (!div_diff[WIDTH]) acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else                  acc_step = {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    assign res_lo = acc_step[WIDTH-1:0];
    assign res_hi = acc_step[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            mode_div <= 1'b0;
        end else if (state == MD_IDLE && start) begin
            cnt      <= '0;
            acc      <= {{WIDTH{1'b0}}, (is_div ? a : b)};
            opnd     <= is_div ? b : a;
            mode_div <= is_div;
        end else if (busy) begin
            cnt <= cnt + CNT_W'(1);
            acc <= acc_step;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle datapath plus iterative MUL/DIV, with registered result and flags.
// Divide-by-zero is resolved immediately and never enters the iterative unit.
module alu_seq import alu_pkg::*; #(
    parameter int WIDTH = 8
) (
    input logic       clk,
    input logic       reset,
    alu_seq_if.slave  bus
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic             md_busy, md_done, md_mode_div;
    logic [WIDTH-1:0] md_lo, md_hi;
    logic             is_div, accept, md_launch, sc_fire;

    logic [WIDTH-1:0] res_q, hi_q;
    logic             cf_q, zf_q, sf_q, of_q, done_q;

    logic [WIDTH:0]   ext;
    logic [WIDTH-1:0] tmp, flag_src, sc_res, sc_hi;
    logic             use_tmp, sc_cf, sc_zf, sc_sf, sc_of, sc_hold;

    function automatic logic add_of(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                    input logic [WIDTH-1:0] r);
        return (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    endfunction

    function automatic logic sub_of(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                    input logic [WIDTH-1:0] r);
        return (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    endfunction

    assign is_div    = (bus.operation == ALU_OP_DIV);
    assign accept    = bus.start && !md_busy;
    assign md_launch = accept && is_multicycle(bus.operation) && !(is_div && bus.B == '0);
    assign sc_fire   = accept && !md_launch;

    alu_muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .reset    (reset),
        .start    (md_launch),
        .is_div   (is_div),
        .a        (bus.A),
        .b        (bus.B),
        .busy     (md_busy),
        .done     (md_done),
        .mode_div (md_mode_div),
        .res_lo   (md_lo),
        .res_hi   (md_hi)
    );

    always_comb begin
        sc_res  = bus.A;
        sc_hi   = '0;
        sc_cf   = cf_q;
        sc_of   = 1'b0;
        sc_hold = 1'b0;
        ext     = '0;
        tmp     = '0;
        use_tmp = 1'b0;
        case (bus.operation)
            ALU_OP_ADD: begin
                ext = {1'b0, bus.A} + {1'b0, bus.B};
                sc_res = ext[WIDTH-1:0]; sc_cf = ext[WIDTH];
                sc_of = add_of(bus.A, bus.B, ext[WIDTH-1:0]);
            end
            ALU_OP_SUB: begin
                ext = {1'b0, bus.A} - {1'b0, bus.B};
                sc_res = ext[WIDTH-1:0]; sc_cf = ext[WIDTH];
                sc_of = sub_of(bus.A, bus.B, ext[WIDTH-1:0]);
            end
            ALU_OP_ADC: begin
                ext = {1'b0, bus.A} + {1'b0, bus.B} + {{WIDTH{1'b0}}, cf_q};
                sc_res = ext[WIDTH-1:0]; sc_cf = ext[WIDTH];
                sc_of = add_of(bus.A, bus.B, ext[WIDTH-1:0]);
            end
            ALU_OP_SBC: begin
                ext = {1'b0, bus.A} - {1'b0, bus.B} - {{WIDTH{1'b0}}, cf_q};
                sc_res = ext[WIDTH-1:0]; sc_cf = ext[WIDTH];
                sc_of = sub_of(bus.A, bus.B, ext[WIDTH-1:0]);
            end
            ALU_OP_AND: begin sc_res = bus.A & bus.B; sc_cf = 1'b0; end
            ALU_OP_OR:  begin sc_res = bus.A | bus.B; sc_cf = 1'b0; end
            ALU_OP_NOT: begin sc_res = ~bus.A;        sc_cf = 1'b0; end
            ALU_OP_XOR: begin sc_res = bus.A ^ bus.B; sc_cf = 1'b0; end
            ALU_OP_INC: begin
                ext = {1'b0, bus.B} + {1'b0, ONE};
                sc_res = ext[WIDTH-1:0]; sc_cf = ext[WIDTH];
                sc_of = add_of(bus.B, ONE, ext[WIDTH-1:0]);
            end
            ALU_OP_DEC: begin
                ext = {1'b0, bus.B} - {1'b0, ONE};
                sc_res = ext[WIDTH-1:0]; sc_cf = ext[WIDTH];
                sc_of = sub_of(bus.B, ONE, ext[WIDTH-1:0]);
            end
            // Compare/test set flags from a scratch value and pass A through untouched.
            ALU_OP_CMP: begin
                ext = {1'b0, bus.A} - {1'b0, bus.B};
                tmp = ext[WIDTH-1:0]; use_tmp = 1'b1; sc_cf = ext[WIDTH];
                sc_of = sub_of(bus.A, bus.B, ext[WIDTH-1:0]);
            end
            ALU_OP_TST: begin tmp = bus.A & bus.B; use_tmp = 1'b1; sc_cf = 1'b0; end
            ALU_OP_SHL,
            ALU_OP_SAL: begin sc_res = {bus.A[WIDTH-2:0], 1'b0};         sc_cf = bus.A[WIDTH-1]; end
            ALU_OP_SHR: begin sc_res = {1'b0, bus.A[WIDTH-1:1]};         sc_cf = bus.A[0]; end
            ALU_OP_SAR: begin sc_res = {bus.A[WIDTH-1], bus.A[WIDTH-1:1]}; sc_cf = bus.A[0]; end
            ALU_OP_ROL: begin sc_res = {bus.A[WIDTH-2:0], bus.A[WIDTH-1]}; sc_cf = bus.A[WIDTH-1]; end
            ALU_OP_ROR: begin sc_res = {bus.A[0], bus.A[WIDTH-1:1]};     sc_cf = bus.A[0]; end
            ALU_OP_RCL: begin sc_res = {bus.A[WIDTH-2:0], cf_q};         sc_cf = bus.A[WIDTH-1]; end
            ALU_OP_RCR: begin sc_res = {cf_q, bus.A[WIDTH-1:1]};         sc_cf = bus.A[0]; end
            ALU_OP_DIV: begin sc_res = '1; sc_hi = bus.A; sc_cf = 1'b1; end
            default:    sc_hold = 1'b1;
        endcase
        flag_src = use_tmp ? tmp : sc_res;
        sc_zf    = (flag_src == '0) && !is_div;
        sc_sf    = flag_src[WIDTH-1] && !is_div;
    end

    // Result/flag register: an iterative completion and a single-cycle launch can never coincide,
    // because the latter requires the iterative unit to be idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_q  <= '0;
            hi_q   <= '0;
            cf_q   <= 1'b0;
            zf_q   <= 1'b0;
            sf_q   <= 1'b0;
            of_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (md_done) begin
                res_q  <= md_lo;
                hi_q   <= md_hi;
                sf_q   <= 1'b0;
                of_q   <= 1'b0;
                done_q <= 1'b1;
                if (md_mode_div) begin
                    cf_q <= 1'b0;
                    zf_q <= (md_lo == '0);
                end else begin
                    cf_q <= (md_hi != '0);
                    zf_q <= ({md_hi, md_lo} == '0);
                end
            end else if (sc_fire) begin
                res_q  <= sc_res;
                hi_q   <= sc_hi;
                done_q <= 1'b1;
                if (!sc_hold) begin
                    cf_q <= sc_cf;
                    zf_q <= sc_zf;
                    sf_q <= sc_sf;
                    of_q <= sc_of;
                end
            end
        end
    end

    assign bus.result    = res_q;
    assign bus.result_hi = hi_q;
    assign bus.CF        = cf_q;
    assign bus.ZF        = zf_q;
    assign bus.SF        = sf_q;
    assign bus.OF        = of_q;
    assign bus.busy      = md_busy;
    assign bus.done      = done_q;

endmodule
